sirv_gnrl_pipe_buf: RTL and testbench

SIRV_GNRL_PIPE_BUF -- requirements
Module: sirv_gnrl_pipe_buf

---
 rtl/sirv_gnrl_pkg.sv | 20 ++
 rtl/sirv_gnrl_dfflr.sv | 29 ++
 rtl/sirv_gnrl_pipe_buf.sv | 141 ++++++++++++++
 tb/tb_sirv_gnrl_pipe_buf.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sirv_gnrl_pkg.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_pkg
// Shared helper constants and functions for the general-purpose pipeline
// buffer family.
//   ptr_width(dp) : width of a read/write pointer for a dp-entry buffer,
//                   never less than 1 bit so a DP=1 buffer still has a
//                   (constant zero) pointer register.
//   cnt_width(dp) : width of an occupancy counter able to hold 0..dp.
// ---------------------------------------------------------------------------
package sirv_gnrl_pkg;

    function automatic int ptr_width(input int dp);
        return (dp > 1) ? $clog2(dp) : 1;
    endfunction

    function automatic int cnt_width(input int dp);
        return $clog2(dp + 1);
    endfunction

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_dfflr
// Load-enabled D flip-flop bank with asynchronous active-low clear.
// Every state bit of the pipeline buffer is built from this cell.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears qout to 0
//   lden  : load enable; qout takes dnxt on the next rising edge when 1
//   dnxt  : next value
//   qout  : registered value
// ---------------------------------------------------------------------------
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_gnrl_pipe_buf.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_pipe_buf
// Valid/ready FIFO pipeline buffer of DP entries, DW bits each, with exactly
// one cycle of latency from input handshake to output visibility.
//
// Parameters
//   DW        : payload width in bits
//   DP        : depth in entries (any integer 1..8)
//   CUT_READY : 1 -> i_rdy depends only on internal state (!full)
//               0 -> i_rdy = !full | o_rdy (accepts into a full buffer that
//                    is being drained in the same cycle)
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_vld/i_rdy/i_dat : upstream handshake and payload
//   o_vld/o_rdy/o_dat : downstream handshake and oldest payload
//   o_cnt          : occupancy, present only when the macro
//                    SIRV_PIPE_BUF_CNT_EN is defined
// ---------------------------------------------------------------------------
module sirv_gnrl_pipe_buf
    import sirv_gnrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter int DP        = 2,
    parameter int CUT_READY = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_vld,
    output logic                      i_rdy,
    input  logic [DW-1:0]             i_dat,
    output logic                      o_vld,
    input  logic                      o_rdy,
    output logic [DW-1:0]             o_dat
`ifdef SIRV_PIPE_BUF_CNT_EN
    ,
    output logic [cnt_width(DP)-1:0]  o_cnt
`endif
);

    localparam int PW = ptr_width(DP);
    localparam int CW = cnt_width(DP);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] mem_reg [DP];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (cnt_reg == CW'(DP));
    assign empty = (cnt_reg == '0);

    generate
        if (CUT_READY != 0) begin : gen_cut_ready
            assign i_rdy = ~full;
        end else begin : gen_pass_ready
            // A full buffer can still take a word when the head leaves in
            // the same cycle; the freed slot is the one being written.
            assign i_rdy = ~full | o_rdy;
        end
    endgenerate

    assign o_vld = ~empty;
    assign push  = i_vld & i_rdy;
    assign pop   = o_vld & o_rdy;

    // Pointers wrap explicitly at DP-1 so non-power-of-two depths work.
    assign wr_ptr_next = (wr_ptr_reg == PW'(DP - 1)) ? '0 : (wr_ptr_reg + PW'(1));
    assign rd_ptr_next = (rd_ptr_reg == PW'(DP - 1)) ? '0 : (rd_ptr_reg + PW'(1));

    always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (pop && !push) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    sirv_gnrl_dfflr #(.DW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (push),
        .dnxt  (wr_ptr_next),
        .qout  (wr_ptr_reg)
    );

    sirv_gnrl_dfflr #(.DW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (pop),
        .dnxt  (rd_ptr_next),
        .qout  (rd_ptr_reg)
    );

    // Count only moves when exactly one of push/pop happens.
    sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (push ^ pop),
        .dnxt  (cnt_next),
        .qout  (cnt_reg)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DP; gi++) begin : gen_entry
            logic entry_lden;
            assign entry_lden = push & (wr_ptr_reg == PW'(gi));

            sirv_gnrl_dfflr #(.DW(DW)) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .lden  (entry_lden),
                .dnxt  (i_dat),
                .qout  (mem_reg[gi])
            );
        end
    endgenerate

    // Read mux over registered storage only: no combinational i_dat path.
    always_comb begin
        o_dat = '0;
        for (int i = 0; i < DP; i++) begin
            if (rd_ptr_reg == PW'(i)) begin
                o_dat = mem_reg[i];
            end
        end
    end

`ifdef SIRV_PIPE_BUF_CNT_EN
    assign o_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_sirv_gnrl_pipe_buf.sv
// ---------------------------------------------------------------------------
// tb_sirv_gnrl_pipe_buf
// Four buffer instances with different depth / ready-cut settings:
//   u0: DP=2 CUT_READY=0   u1: DP=3 CUT_READY=0
//   u2: DP=2 CUT_READY=1   u3: DP=1 CUT_READY=1
// Each is compared against a queue-based reference of a bounded FIFO.
// ---------------------------------------------------------------------------
module tb_sirv_gnrl_pipe_buf;

    localparam int NI = 4;

    function automatic int dp_of(input int k);
        case (k)
            0: return 2;
            1: return 3;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cr_of(input int k);
        case (k)
            0: return 0;
            1: return 0;
            default: return 1;
        endcase
    endfunction

    logic        clk;
    logic        rst_n;
    logic        i_vld [NI];
    logic        i_rdy [NI];
    logic [31:0] i_dat [NI];
    logic        o_vld [NI];
    logic        o_rdy [NI];
    logic [31:0] o_dat [NI];
    logic [3:0]  o_cnt [NI];

    logic [31:0] mq [NI][$];

    int checks = 0;
    int passed = 0;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : gen_dut
            localparam int DPG = dp_of(g);
            localparam int CRG = cr_of(g);
`ifdef SIRV_PIPE_BUF_CNT_EN
            logic [$clog2(DPG+1)-1:0] cnt_w;
            assign o_cnt[g] = 4'(cnt_w);
`else
            assign o_cnt[g] = 4'd0;
`endif
            sirv_gnrl_pipe_buf #(.DW(32), .DP(DPG), .CUT_READY(CRG)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .i_vld (i_vld[g]),
                .i_rdy (i_rdy[g]),
                .i_dat (i_dat[g]),
                .o_vld (o_vld[g]),
                .o_rdy (o_rdy[g]),
                .o_dat (o_dat[g])
`ifdef SIRV_PIPE_BUF_CNT_EN
                ,
                .o_cnt (cnt_w)
`endif
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bounded FIFO. Ready if not full, or (pass-through mode)
    // downstream is taking the head this cycle.
    function automatic bit model_rdy(input int k, input bit ordy);
        if (mq[k].size() < dp_of(k)) return 1'b1;
        if (cr_of(k) == 0 && ordy) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle on instance k, other instances idle. Returns observed and
    // expected i_rdy before the edge; the model is advanced at the edge.
    task automatic step(input int k, input bit vld, input bit ordy,
                        input logic [31:0] dat,
                        output bit rdy_obs, output bit rdy_exp);
        bit push;
        bit pop;
        for (int j = 0; j < NI; j++) begin
            i_vld[j] = 1'b0;
            o_rdy[j] = 1'b0;
        end
        i_vld[k] = vld;
        o_rdy[k] = ordy;
        i_dat[k] = dat;
        #1;
        rdy_obs = i_rdy[k];
        rdy_exp = model_rdy(k, ordy);
        push = vld && rdy_exp;
        pop  = (mq[k].size() != 0) && ordy;
        @(posedge clk);
        if (pop)  void'(mq[k].pop_front());
        if (push) mq[k].push_back(dat);
        $display("[%0t] u%0d vld=%0b rdy=%0b dat=%h ordy=%0b push=%0b pop=%0b occ=%0d",
                 $time, k, vld, rdy_obs, dat, ordy, push, pop, mq[k].size());
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        for (int j = 0; j < NI; j++) mq[j].delete();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int j = 0; j < NI; j++) begin
            i_vld[j] = 1'b0;
            o_rdy[j] = 1'b0;
            i_dat[j] = 32'h0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        assert_reset();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (o_vld[k] !== 1'b0) $display("FAIL reset_ovld: u%0d got %b want 0", k, o_vld[k]);
            else passed++;
            checks++;
            if (i_rdy[k] !== 1'b1) $display("FAIL reset_irdy: u%0d got %b want 1", k, i_rdy[k]);
            else passed++;
            checks++;
            if (o_dat[k] !== 32'h0) $display("FAIL reset_odat: u%0d got %h want 0", k, o_dat[k]);
            else passed++;
`ifdef SIRV_PIPE_BUF_CNT_EN
            checks++;
            if (o_cnt[k] !== 4'd0) $display("FAIL reset_ocnt: u%0d got %0d want 0", k, o_cnt[k]);
            else passed++;
`endif
        end
        release_reset();
    endtask

    task automatic test_single_latency();
        bit ro, re;
        step(0, 1'b1, 1'b1, 32'hA5A5A5A5, ro, re);
        checks++;
        if (o_vld[0] !== 1'b1) $display("FAIL lat_ovld1: got %b want 1", o_vld[0]);
        else passed++;
        checks++;
        if (o_dat[0] !== 32'hA5A5A5A5) $display("FAIL lat_odat: got %h want a5a5a5a5", o_dat[0]);
        else passed++;
        step(0, 1'b0, 1'b1, 32'h0, ro, re);
        checks++;
        if (o_vld[0] !== 1'b0) $display("FAIL lat_ovld2: got %b want 0", o_vld[0]);
        else passed++;
    endtask

    task automatic test_fill_drain();
        bit ro, re;
        logic [31:0] seen [$];
        logic [31:0] want [4];
        want[0] = 32'h1; want[1] = 32'h2; want[2] = 32'h3; want[3] = 32'h4;
        for (int i = 1; i <= 3; i++) begin
            step(1, 1'b1, 1'b0, 32'(i), ro, re);
        end
        step(1, 1'b1, 1'b0, 32'h4, ro, re);
        checks++;
        if (ro !== 1'b0) $display("FAIL full_irdy: got %b want 0", ro);
        else passed++;
        checks++;
        if (mq[1].size() != 3) $display("FAIL full_occ: model %0d want 3", mq[1].size());
        else passed++;
`ifdef SIRV_PIPE_BUF_CNT_EN
        checks++;
        if (o_cnt[1] !== 4'd3) $display("FAIL full_ocnt: got %0d want 3", o_cnt[1]);
        else passed++;
`endif
        // Release: the 0x4 retry is accepted while the head leaves.
        for (int i = 0; i < 6; i++) begin
            if (o_vld[1] === 1'b1) seen.push_back(o_dat[1]);
            step(1, (i == 0), 1'b1, 32'h4, ro, re);
            if (i == 0) begin
                checks++;
                if (ro !== 1'b1) $display("FAIL drain_irdy: got %b want 1", ro);
                else passed++;
            end
        end
        checks++;
        if (seen.size() != 4) $display("FAIL drain_len: got %0d want 4", seen.size());
        else passed++;
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== want[i]) $display("FAIL drain_order: idx %0d got %h want %h", i, seen[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_full_passthru();
        bit ro, re;
        step(0, 1'b1, 1'b0, 32'h10, ro, re);
        step(0, 1'b1, 1'b0, 32'h11, ro, re);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] head;
            head = mq[0][0];
            step(0, 1'b1, 1'b1, 32'h20 + 32'(i), ro, re);
            checks++;
            if (ro !== 1'b1) $display("FAIL pass_irdy: cyc %0d got %b want 1", i, ro);
            else passed++;
            checks++;
            if (mq[0].size() != 2 || o_vld[0] !== 1'b1) $display("FAIL pass_occ: cyc %0d vld %b occ %0d want 1/2", i, o_vld[0], mq[0].size());
            else passed++;
            checks++;
            if (o_dat[0] !== mq[0][0] || mq[0][0] === head) $display("FAIL pass_odat: cyc %0d got %h want %h", i, o_dat[0], mq[0][0]);
            else passed++;
`ifdef SIRV_PIPE_BUF_CNT_EN
            checks++;
            if (o_cnt[0] !== 4'd2) $display("FAIL pass_ocnt: cyc %0d got %0d want 2", i, o_cnt[0]);
            else passed++;
`endif
        end
    endtask

    task automatic test_cut_ready();
        bit ro, re;
        step(2, 1'b1, 1'b0, 32'h31, ro, re);
        step(2, 1'b1, 1'b0, 32'h32, ro, re);
        step(2, 1'b1, 1'b1, 32'h33, ro, re);
        checks++;
        if (ro !== 1'b0) $display("FAIL cut_irdy0: got %b want 0", ro);
        else passed++;
        checks++;
        if (o_dat[2] !== 32'h32) $display("FAIL cut_odat: got %h want 00000032", o_dat[2]);
        else passed++;
        step(2, 1'b1, 1'b1, 32'h33, ro, re);
        checks++;
        if (ro !== 1'b1) $display("FAIL cut_irdy1: got %b want 1", ro);
        else passed++;
        checks++;
        if (o_dat[2] !== 32'h33) $display("FAIL cut_odat2: got %h want 00000033", o_dat[2]);
        else passed++;
    endtask

    task automatic test_dp1_throughput();
        bit ro, re;
        int accepted = 0;
        for (int i = 0; i < 6; i++) begin
            step(3, 1'b1, 1'b1, 32'h40 + 32'(i), ro, re);
            if (ro) accepted++;
            checks++;
            if (ro !== re) $display("FAIL dp1_irdy: cyc %0d got %b want %b", i, ro, re);
            else passed++;
        end
        checks++;
        if (accepted != 3) $display("FAIL dp1_rate: got %0d want 3", accepted);
        else passed++;
        step(3, 1'b0, 1'b1, 32'h0, ro, re);
    endtask

    // Shared by wrap and random tests: compare one instance to the model.
    task automatic run_random(input int k, input int cycles, input int wrds,
                              input bit bounded, input string tag);
        bit ro, re;
        int pushed = 0;
        int cyc = 0;
        while (cyc < cycles) begin
            bit vld, ordy;
            vld  = bounded ? (pushed < wrds) : ($urandom_range(0, 9) < 7);
            ordy = (bounded && cyc > 40) ? 1'b1 : ($urandom_range(0, 9) < 5);
            step(k, vld, ordy, $urandom, ro, re);
            if (vld && re) pushed++;
            cyc++;
            checks++;
            if (ro !== re) $display("FAIL %s_irdy: u%0d cyc %0d got %b want %b", tag, k, cyc, ro, re);
            else passed++;
            checks++;
            if (o_vld[k] !== (mq[k].size() != 0)) $display("FAIL %s_ovld: u%0d cyc %0d got %b want %0b", tag, k, cyc, o_vld[k], mq[k].size() != 0);
            else passed++;
            if (mq[k].size() != 0) begin
                checks++;
                if (o_dat[k] !== mq[k][0]) $display("FAIL %s_odat: u%0d cyc %0d got %h want %h", tag, k, cyc, o_dat[k], mq[k][0]);
                else passed++;
            end
`ifdef SIRV_PIPE_BUF_CNT_EN
            checks++;
            if (o_cnt[k] !== 4'(mq[k].size())) $display("FAIL %s_ocnt: u%0d cyc %0d got %0d want %0d", tag, k, cyc, o_cnt[k], mq[k].size());
            else passed++;
`endif
            if (bounded && pushed >= wrds && mq[k].size() == 0) break;
        end
        if (bounded) begin
            checks++;
            if (pushed != wrds || mq[k].size() != 0) $display("FAIL %s_done: u%0d pushed %0d occ %0d want %0d/0", tag, k, pushed, mq[k].size(), wrds);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        run_random(1, 100, 7, 1'b1, "wrap");
    endtask

    task automatic test_mid_reset();
        bit ro, re;
        step(0, 1'b1, 1'b0, 32'h61, ro, re);
        step(0, 1'b1, 1'b0, 32'h62, ro, re);
        assert_reset();
        checks++;
        if (o_vld[0] !== 1'b0) $display("FAIL mrst_ovld: got %b want 0", o_vld[0]);
        else passed++;
        checks++;
        if (i_rdy[0] !== 1'b1) $display("FAIL mrst_irdy: got %b want 1", i_rdy[0]);
        else passed++;
`ifdef SIRV_PIPE_BUF_CNT_EN
        checks++;
        if (o_cnt[0] !== 4'd0) $display("FAIL mrst_ocnt: got %0d want 0", o_cnt[0]);
        else passed++;
`endif
        release_reset();
        step(0, 1'b1, 1'b0, 32'h55, ro, re);
        checks++;
        if (o_vld[0] !== 1'b1 || o_dat[0] !== 32'h55) $display("FAIL mrst_first: got %b/%h want 1/00000055", o_vld[0], o_dat[0]);
        else passed++;
        step(0, 1'b0, 1'b1, 32'h0, ro, re);
        checks++;
        if (o_vld[0] !== 1'b0) $display("FAIL mrst_drain: got %b want 0", o_vld[0]);
        else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < NI; k++) begin
            run_random(k, 60, 0, 1'b0, "rand");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_latency();
        test_fill_drain();
        test_full_passthru();
        test_cut_ready();
        test_dp1_throughput();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
